// File: rtl/program_loader_if.sv
// Byte-stream receive handshake plus instruction-memory write port for the boot loader.
// The master side is the loader; the slave side is the byte source and the memory.
interface program_loader_if #(
  parameter int unsigned ADDR_WIDTH = 9
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [ADDR_WIDTH-1:0] im_addr;
  logic [15:0]           im_data;
  logic                  im_we;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, im_addr, im_data, im_we
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, im_addr, im_data, im_we
  );
endinterface

// File: rtl/program_loader.sv
// Boot-time loader: receives a length-prefixed, XOR-checksummed byte frame and writes
// 16-bit words into instruction memory, then releases the core from reset.
module program_loader #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DEPTH      = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  program_loader_if.master      bus,
  output logic                  core_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned CNT_W = 10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [7:0]        len_hi;
  logic [7:0]        xor_acc;
  logic [CNT_W-1:0]  remaining;
  logic [15:0]       len_word;
  logic              len_over;
  logic              chk_good;
  logic              accept;

  logic              rx_ready_nxt;
  logic              im_we_nxt;
  logic              core_rst_n_nxt;
  logic              busy_nxt;
  logic              done_nxt;
  logic              error_nxt;

  // rx_ready is a registered copy of the state decode, so accept has no loop through rx_valid
  assign accept   = bus.rx_valid && bus.rx_ready;
  assign len_word = {len_hi, bus.rx_data};
  assign len_over = len_word > 16'(DEPTH);
  assign chk_good = (xor_acc ^ bus.rx_data) == 8'h00;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (load_start) state_nxt = S_LEN_HI;
      S_LEN_HI:  if (accept) state_nxt = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if (len_over)               state_nxt = S_ERROR;
          else if (len_word == 16'd0) state_nxt = S_CHECK;
          else                        state_nxt = S_DATA_HI;
        end
      end
      S_DATA_HI: if (accept) state_nxt = S_DATA_LO;
      S_DATA_LO: if (accept) state_nxt = S_WRITE;
      // remaining still holds the pre-decrement count here
      S_WRITE:   state_nxt = (remaining == CNT_W'(1)) ? S_CHECK : S_DATA_HI;
      S_CHECK:   if (accept) state_nxt = chk_good ? S_DONE : S_ERROR;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from the next state and registered, so they track the state register exactly
  always_comb begin
    rx_ready_nxt   = 1'b0;
    im_we_nxt      = 1'b0;
    core_rst_n_nxt = 1'b0;
    busy_nxt       = 1'b0;
    done_nxt       = 1'b0;
    error_nxt      = 1'b0;
    case (state_nxt)
      S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHECK: begin
        rx_ready_nxt = 1'b1;
        busy_nxt     = 1'b1;
      end
      S_WRITE: begin
        im_we_nxt = 1'b1;
        busy_nxt  = 1'b1;
      end
      S_DONE: begin
        done_nxt       = 1'b1;
        core_rst_n_nxt = 1'b1;
      end
      S_ERROR: error_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rx_ready <= 1'b0;
      bus.im_we    <= 1'b0;
      core_rst_n   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      bus.rx_ready <= rx_ready_nxt;
      bus.im_we    <= im_we_nxt;
      core_rst_n   <= core_rst_n_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      error        <= error_nxt;
    end
  end

  // Frame datapath: length capture, word assembly, address/count stepping and running XOR
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.im_addr <= '0;
      bus.im_data <= '0;
      remaining   <= '0;
      xor_acc     <= '0;
      len_hi      <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (load_start) begin
            bus.im_addr <= '0;
            remaining   <= '0;
            xor_acc     <= '0;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            len_hi  <= bus.rx_data;
            xor_acc <= xor_acc ^ bus.rx_data;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            remaining <= len_word[CNT_W-1:0];
            xor_acc   <= xor_acc ^ bus.rx_data;
          end
        end
        S_DATA_HI: begin
          if (accept) begin
            bus.im_data[15:8] <= bus.rx_data;
            xor_acc           <= xor_acc ^ bus.rx_data;
          end
        end
        S_DATA_LO: begin
          if (accept) begin
            bus.im_data[7:0] <= bus.rx_data;
            xor_acc          <= xor_acc ^ bus.rx_data;
          end
        end
        S_WRITE: begin
          bus.im_addr <= bus.im_addr + ADDR_WIDTH'(1);
          remaining   <= remaining - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
